// File: rtl/secuenciador_instrucciones.sv
// ---------------------------------------------------------------------------
// secuenciador_instrucciones
//
// Instruction issuer for the register-file / ALU / result-memory datapath.
// A small program memory is loaded while the issuer is idle. A start request
// replays the first `longitud` words, one per cycle, from address 0. A
// one-cycle `fin` pulse marks completion. Whenever nothing is issued (idle,
// stalled or finishing), the all-zero NOP word is presented, so neither
// datapath write-enable is asserted.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst          synchronous reset, active-high
//   i_prog_we      program-memory write strobe (honoured only in IDLE)
//   i_prog_dir     program write address
//   i_prog_dato    program word (datapath instruction layout)
//   i_inicio       start request (sampled only in IDLE)
//   i_longitud     words to issue, 1..PROF (larger values saturate to PROF)
//   i_pausa        stall request while running
//   o_instruccion  registered instruction word to the datapath
//   o_valido       o_instruccion holds a real program word
//   o_ocupado      high in RUN and FIN
//   o_fin          one-cycle completion pulse
//   o_pc           address of the next word to issue
// ---------------------------------------------------------------------------
// state  | meaning
// S_IDLE | waiting; program writes and start requests accepted
// S_RUN  | issuing one word per unstalled cycle until the count runs out
// S_FIN  | one NOP cycle that raises fin and returns to idle
// ---------------------------------------------------------------------------
module secuenciador_instrucciones #(
    parameter int PROF = 32,
    parameter int AW   = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_prog_we,
    input  logic [AW-1:0] i_prog_dir,
    input  logic [19:0]   i_prog_dato,
    input  logic          i_inicio,
    input  logic [AW:0]   i_longitud,
    input  logic          i_pausa,
    output logic [19:0]   o_instruccion,
    output logic          o_valido,
    output logic          o_ocupado,
    output logic          o_fin,
    output logic [AW-1:0] o_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } estado_t;

    localparam logic [AW:0] PROF_W = (AW+1)'(PROF);
    localparam logic [AW:0] UNO_W  = (AW+1)'(1);

    estado_t       r_estado;
    estado_t       w_estado_sig;

    logic [19:0]   r_mem [PROF];

    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_sig;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_sig;
    logic [19:0]   r_instr;
    logic [19:0]   w_instr_sig;
    logic          r_valido;
    logic          w_valido_sig;
    logic          r_fin;
    logic          w_fin_sig;

    logic [AW:0]   w_long_sat;
    logic          w_arranque;
    logic          w_escritura;

    // Over-length requests replay the whole memory exactly once.
    assign w_long_sat  = (i_longitud > PROF_W) ? PROF_W : i_longitud;

    // A zero-length start is dropped silently: no run, no fin pulse.
    assign w_arranque  = (r_estado == S_IDLE) && i_inicio && (i_longitud != '0);

    // The program is frozen while a run is in progress.
    assign w_escritura = (r_estado == S_IDLE) && i_prog_we && !i_rst;

    // Next-state and next-output logic. Every non-issuing cycle drives NOP.
    always_comb begin
        w_estado_sig = r_estado;
        w_pc_sig     = r_pc;
        w_cnt_sig    = r_cnt;
        w_instr_sig  = '0;
        w_valido_sig = 1'b0;
        w_fin_sig    = 1'b0;

        unique case (r_estado)
            S_IDLE: begin
                if (w_arranque) begin
                    w_estado_sig = S_RUN;
                    w_pc_sig     = '0;
                    w_cnt_sig    = w_long_sat;
                end
            end

            S_RUN: begin
                if (!i_pausa) begin
                    w_instr_sig  = r_mem[r_pc];
                    w_valido_sig = 1'b1;
                    // Natural AW-bit wrap; a full-length run ends back at 0.
                    w_pc_sig     = r_pc + 1'b1;
                    w_cnt_sig    = r_cnt - 1'b1;
                    if (r_cnt == UNO_W) begin
                        w_estado_sig = S_FIN;
                    end
                end
            end

            S_FIN: begin
                w_fin_sig    = 1'b1;
                w_pc_sig     = '0;
                w_estado_sig = S_IDLE;
            end

            default: begin
                w_estado_sig = S_IDLE;
                w_pc_sig     = '0;
                w_cnt_sig    = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_estado <= S_IDLE;
            r_pc     <= '0;
            r_cnt    <= '0;
            r_instr  <= '0;
            r_valido <= 1'b0;
            r_fin    <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            r_pc     <= w_pc_sig;
            r_cnt    <= w_cnt_sig;
            r_instr  <= w_instr_sig;
            r_valido <= w_valido_sig;
            r_fin    <= w_fin_sig;
        end
    end

    // Program storage is deliberately outside reset so a reset mid-run keeps
    // the loaded program intact.
    always_ff @(posedge i_clk) begin
        if (w_escritura) begin
            r_mem[i_prog_dir] <= i_prog_dato;
        end
    end

    assign o_instruccion = r_instr;
    assign o_valido      = r_valido;
    assign o_ocupado     = (r_estado != S_IDLE);
    assign o_fin         = r_fin;
    assign o_pc          = r_pc;

endmodule
